// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, fetch FSM states and PC helpers.
// Imported by fetch_unit and fetch_buf.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(WORD_BYTES);
  endfunction

  function automatic word_t word_align(input word_t a);
    return a & ~word_t'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry hold buffer for a fetched word and its PC+4.
// Parks a hit that the IF/ID latch could not accept.
module fetch_buf
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clr,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o
);

  word_t instr_q, instr_d;
  word_t npc_q, npc_d;
  logic  valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (load) begin
      instr_d = instr_i;
      npc_d   = npc_i;
      valid_d = 1'b1;
    end else if (clr) begin
      instr_d = '0;
      npc_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (FETCH/HOLD/DROP/HALTED) feeding IF/ID.
// Define FETCH_PERF_EN to add perf_fetch_cnt / perf_stall_cnt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_npc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t state_q, state_d;
  word_t pc_q, pc_d;
  word_t drop_addr_q, drop_addr_d;

  logic  buf_load, buf_clr, buf_valid;
  word_t buf_instr, buf_npc;
  word_t tgt;

  assign tgt = word_align(redirect_pc);

  fetch_buf u_buf (
    .clk     (CLK),
    .rst     (RST),
    .load    (buf_load),
    .clr     (buf_clr),
    .instr_i (iload),
    .npc_i   (pc_inc(pc_q)),
    .instr_o (buf_instr),
    .npc_o   (buf_npc),
    .valid_o (buf_valid)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    iREN        = 1'b0;
    iaddr       = pc_q;
    fetch_valid = 1'b0;
    fetch_instr = iload;
    fetch_npc   = pc_inc(pc_q);
    buf_load    = 1'b0;
    buf_clr     = 1'b0;
    unique case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          pc_d = tgt;
          if (!ihit) begin
            // the miss stays outstanding; keep its address until it lands
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (ihit) begin
          pc_d = pc_inc(pc_q);
          if (stall) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            fetch_valid = 1'b1;
          end
        end
      end
      HOLD: begin
        fetch_instr = buf_instr;
        fetch_npc   = buf_npc;
        if (halt) begin
          buf_clr = 1'b1;
          state_d = HALTED;
        end else if (redirect) begin
          buf_clr = 1'b1;
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!stall) begin
          fetch_valid = buf_valid;
          buf_clr     = 1'b1;
          state_d     = FETCH;
        end
      end
      DROP: begin
        iREN  = 1'b1;
        iaddr = drop_addr_q;
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          pc_d = tgt;
        end else if (ihit) begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (RST) begin
      fetch_valid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (fetch_valid) begin
      fcnt_d = fcnt_q + 32'd1;
    end
    if (iREN && !ihit) begin
      scnt_d = scnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign perf_fetch_cnt = fcnt_q;
  assign perf_stall_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then random traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] PCI = 32'h0000_0100;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_npc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(.PC_INIT(PCI)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .iload       (iload),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_npc   (fetch_npc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        e_iren;
    logic        chk_addr;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic h, logic [31:0] ld, logic s, logic rd,
    logic [31:0] rp, logic hl, logic ei, logic ca,
    logic [31:0] ea, logic ev, logic [31:0] ein, logic [31:0] en);
    vec_t v;
    v.rst = r; v.ihit = h; v.iload = ld; v.stall = s;
    v.redir = rd; v.rpc = rp; v.halt = hl;
    v.e_iren = ei; v.chk_addr = ca; v.e_iaddr = ea;
    v.e_valid = ev; v.e_instr = ein; v.e_npc = en;
    return v;
  endfunction

  // Behavioural model: pending-hold, pending-drop and halted flags.
  bit          m_halted, m_held, m_drop;
  logic [31:0] m_pc, m_daddr, m_hinstr, m_hnpc;
  logic [31:0] m_fcnt, m_scnt;
  logic        o_iren, o_valid;
  logic [31:0] o_iaddr, o_instr, o_npc;

  task automatic model_out();
    o_iren  = 1'b0;
    o_valid = 1'b0;
    o_iaddr = m_pc;
    o_instr = iload;
    o_npc   = m_pc + 32'd4;
    if (m_halted) begin
      o_iren = 1'b0;
    end else if (m_held) begin
      o_valid = !stall && !redirect && !halt;
      o_instr = m_hinstr;
      o_npc   = m_hnpc;
    end else if (m_drop) begin
      o_iren  = 1'b1;
      o_iaddr = m_daddr;
    end else begin
      o_iren  = 1'b1;
      o_valid = ihit && !stall && !redirect && !halt;
    end
    if (RST) o_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    t = {redirect_pc[31:2], 2'b00};
    if (RST) begin
      m_halted = 0; m_held = 0; m_drop = 0;
      m_pc = PCI; m_daddr = 0; m_fcnt = 0; m_scnt = 0;
      return;
    end
    if (o_valid) m_fcnt++;
    if (o_iren && !ihit) m_scnt++;
    if (halt) begin
      m_halted = 1; m_held = 0; m_drop = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_held) begin
      if (redirect) begin
        m_held = 0; m_pc = t;
      end else if (!stall) begin
        m_held = 0;
      end
    end else if (m_drop) begin
      if (redirect) m_pc = t;
      else if (ihit) m_drop = 0;
    end else if (redirect) begin
      if (!ihit) begin
        m_drop = 1; m_daddr = m_pc;
      end
      m_pc = t;
    end else if (ihit) begin
      if (stall) begin
        m_held = 1; m_hinstr = iload; m_hnpc = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    RST = 1; ihit = 0; iload = 0; stall = 0;
    redirect = 0; redirect_pc = 0; halt = 0;

    // r ihit iload stall redir rpc halt | iren chka iaddr valid instr npc
    vecs.push_back(mk(1,1,32'hAAAA0001,0,0,0,0, 1,1,32'h100, 0,0,0));
    vecs.push_back(mk(0,1,32'hAAAA0001,0,0,0,0, 1,1,32'h100, 1,32'hAAAA0001,32'h104));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,1,32'h104, 0,0,0));
    vecs.push_back(mk(0,1,32'hBBBB0002,1,0,0,0, 1,1,32'h104, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,32'h5,1,0,0,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 1,32'hBBBB0002,32'h108));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,1,32'h108, 0,0,0));
    vecs.push_back(mk(0,1,32'h7,0,1,32'h200,0, 1,1,32'h108, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,1,32'h200, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h403,0, 1,1,32'h200, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,1,32'h200, 0,0,0));
    vecs.push_back(mk(0,1,32'hDEAD,0,0,0,0, 1,1,32'h200, 0,0,0));
    vecs.push_back(mk(0,1,32'h11110003,0,0,0,0, 1,1,32'h400, 1,32'h11110003,32'h404));
    vecs.push_back(mk(0,1,32'h22220004,1,0,0,0, 1,1,32'h404, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'hFFFFFFFE,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,32'h33330005,0,0,0,0, 1,1,32'hFFFFFFFC, 1,32'h33330005,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,1,32'h0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h800,0, 1,1,32'h0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'hC00,0, 1,1,32'h0, 0,0,0));
    vecs.push_back(mk(0,1,32'h9,0,1,32'hC00,1, 1,1,32'h0, 0,0,0));
    vecs.push_back(mk(0,1,32'h9,0,1,32'h40,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,32'h9,0,0,0,0, 0,0,0, 0,0,0));

    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst; ihit = vecs[i].ihit; iload = vecs[i].iload;
      stall = vecs[i].stall; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; halt = vecs[i].halt;
      #4;
      chk($sformatf("v%0d iREN", i), {31'b0, iREN}, {31'b0, vecs[i].e_iren});
      chk($sformatf("v%0d valid", i), {31'b0, fetch_valid},
          {31'b0, vecs[i].e_valid});
      if (vecs[i].chk_addr)
        chk($sformatf("v%0d iaddr", i), iaddr, vecs[i].e_iaddr);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d instr", i), fetch_instr, vecs[i].e_instr);
        chk($sformatf("v%0d npc", i), fetch_npc, vecs[i].e_npc);
      end
      @(posedge CLK);
      #1;
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch_dir", perf_fetch_cnt, 32'd4);
    chk("perf_stall_dir", perf_stall_cnt, 32'd8);
`endif

    // Random traffic; rare resets land mid-HOLD/DROP and clear halts.
    RST = 1; ihit = 0; stall = 0; redirect = 0; halt = 0;
    model_out();
    @(posedge CLK);
    model_step();
    #1;
    for (int c = 0; c < 800; c++) begin
      RST   = ($urandom_range(0, 39) == 0);
      ihit  = ($urandom_range(0, 2) != 0);
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      halt  = ($urandom_range(0, 79) == 0);
      iload = $urandom;
      redirect_pc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFD : $urandom;
      model_out();
      #4;
      chk($sformatf("r%0d iREN", c), {31'b0, iREN}, {31'b0, o_iren});
      chk($sformatf("r%0d valid", c), {31'b0, fetch_valid}, {31'b0, o_valid});
      if (o_iren) chk($sformatf("r%0d iaddr", c), iaddr, o_iaddr);
      if (o_valid) begin
        chk($sformatf("r%0d instr", c), fetch_instr, o_instr);
        chk($sformatf("r%0d npc", c), fetch_npc, o_npc);
      end
`ifdef FETCH_PERF_EN
      chk($sformatf("r%0d pfetch", c), perf_fetch_cnt, m_fcnt);
      chk($sformatf("r%0d pstall", c), perf_stall_cnt, m_scnt);
`endif
      @(posedge CLK);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
